spu_issue_ctrl: RTL and testbench

// - Dual-issue scheduler in front of the SPU even/odd pipes.
// - Takes an in-order instruction pair from decode and decides per cycle which slot issues to which pipe.
// - Tracks in-flight destination registers in a latency scoreboard and stalls on RAW/WAW and structural hazards.
// - Forwarding covers results once their pipe latency has elapsed; this block only guarantees that timing.

---
 rtl/spu_issue_ctrl_pkg.sv | 38 +++
 rtl/spu_issue_ctrl_scoreboard.sv | 53 +++++
 rtl/spu_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_spu_issue_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spu_issue_ctrl_pkg.sv
// Shared types for the SPU dual-issue controller: the decoded slot format,
// pipe and state encodings, and a small operand helper.
package spu_issue_ctrl_pkg;

  localparam int SLOT_REG_W = 7;
  localparam int SLOT_LAT_W = 3;
  localparam int MIN_LAT    = 2;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_e;

  typedef enum logic {
    IS_PAIR = 1'b0,
    IS_S1   = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic                  valid;
    pipe_e                 pipe;
    logic [SLOT_LAT_W-1:0] lat;
    logic                  rt_wr;
    logic [SLOT_REG_W-1:0] rt;
    logic [2:0]            src_en;
    logic [SLOT_REG_W-1:0] ra;
    logic [SLOT_REG_W-1:0] rb;
    logic [SLOT_REG_W-1:0] rc;
  } issue_slot_t;

  // True when any enabled source operand of the slot names register r.
  function automatic logic reads_reg(input issue_slot_t s, input logic [SLOT_REG_W-1:0] r);
    return (s.src_en[0] && (s.ra == r)) ||
           (s.src_en[1] && (s.rb == r)) ||
           (s.src_en[2] && (s.rc == r));
  endfunction

endpackage

// File: rtl/spu_issue_ctrl_scoreboard.sv
// Latency scoreboard: one countdown per architectural register. A nonzero
// count means the producer's result is not yet reachable through forwarding.
module spu_scoreboard
  import spu_issue_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 3,
  parameter int REG_W    = SLOT_REG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0][2:0][REG_W-1:0]  rd_addr,
  output logic [1:0][2:0]             rd_busy,
  input  logic [1:0][REG_W-1:0]       rt_addr,
  output logic [1:0]                  rt_busy,
  input  logic [1:0]                  set_en,
  input  logic [1:0][REG_W-1:0]       set_addr,
  input  logic [1:0][LAT_W-1:0]       set_val
);

  logic [LAT_W-1:0] cnt [NUM_REGS];

  // Read ports: a register is busy while its countdown is nonzero.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++) begin
        rd_busy[s][k] = (cnt[rd_addr[s][k]] != '0);
      end
      rt_busy[s] = (cnt[rt_addr[s]] != '0);
    end
  end

  // Countdown update: slot1's set wins a same-register collision, otherwise
  // slot0's set, otherwise drain by one toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (set_en[1] && (set_addr[1] == REG_W'(r))) begin
          cnt[r] <= set_val[1];
        end else if (set_en[0] && (set_addr[0] == REG_W'(r))) begin
          cnt[r] <= set_val[0];
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spu_issue_ctrl.sv
// Dual-issue scheduler ahead of the SPU even/odd pipes. Issues an in-order
// decode pair to the two pipes, holding back slots on RAW/WAW and pipe
// conflicts, and counts cycles where a presented pair made no progress.
module spu_issue_ctrl
  import spu_issue_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = SLOT_LAT_W,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pair_valid,
  input  issue_slot_t        slot0,
  input  issue_slot_t        slot1,
  input  logic               flush,
  output logic               pair_ready,
  output logic               issue_ep,
  output logic               issue_ep_sel,
  output logic               issue_op,
  output logic               issue_op_sel,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int REG_W = SLOT_REG_W;

  issue_state_e state;
  issue_state_e state_nxt;

  logic [1:0][2:0][REG_W-1:0] rd_addr;
  logic [1:0][2:0]            rd_busy;
  logic [1:0][REG_W-1:0]      rt_addr;
  logic [1:0]                 rt_busy;
  logic [1:0]                 set_en;
  logic [1:0][REG_W-1:0]      set_addr;
  logic [1:0][LAT_W-1:0]      set_val;

  logic sok0;
  logic sok1;
  logic dep1;
  logic pipe_clash;
  logic go0;
  logic go1;
  logic stall;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  assign rd_addr[0] = {slot0.rc, slot0.rb, slot0.ra};
  assign rd_addr[1] = {slot1.rc, slot1.rb, slot1.ra};
  assign rt_addr[0] = slot0.rt;
  assign rt_addr[1] = slot1.rt;

  spu_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W),
    .REG_W    (REG_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .rt_addr  (rt_addr),
    .rt_busy  (rt_busy),
    .set_en   (set_en),
    .set_addr (set_addr),
    .set_val  (set_val)
  );

  // Per-slot readiness against the scoreboard and the intra-pair hazards
  // that keep slot1 from dual-issuing alongside slot0.
  always_comb begin
    sok0       = ~|(slot0.src_en & rd_busy[0]) && !(slot0.rt_wr && rt_busy[0]);
    sok1       = ~|(slot1.src_en & rd_busy[1]) && !(slot1.rt_wr && rt_busy[1]);
    dep1       = slot0.valid && slot0.rt_wr &&
                 (reads_reg(slot1, slot0.rt) || (slot1.rt_wr && (slot1.rt == slot0.rt)));
    pipe_clash = slot0.valid && slot1.valid && (slot1.pipe == slot0.pipe);
  end

  // Issue decision and next state; invalid slots count as already issued.
  always_comb begin
    go0        = 1'b0;
    go1        = 1'b0;
    pair_ready = 1'b0;
    state_nxt  = state;
    if (rst) begin
      state_nxt = IS_PAIR;
    end else if (flush) begin
      state_nxt = IS_PAIR;
    end else if (pair_valid) begin
      case (state)
        IS_PAIR: begin
          if (!slot0.valid || sok0) begin
            go0 = slot0.valid;
            if (!slot1.valid || (sok1 && !pipe_clash && !dep1)) begin
              go1        = slot1.valid;
              pair_ready = 1'b1;
            end else begin
              state_nxt = IS_S1;
            end
          end
        end
        IS_S1: begin
          if (!slot1.valid || sok1) begin
            go1        = slot1.valid;
            pair_ready = 1'b1;
            state_nxt  = IS_PAIR;
          end
        end
        default: state_nxt = IS_PAIR;
      endcase
    end
    stall = pair_valid && !flush && !rst && !go0 && !go1 && !pair_ready;
  end

  // Pipe routing and scoreboard set ports driven from the issue decision.
  always_comb begin
    issue_ep     = (go0 && (slot0.pipe == PIPE_EVEN)) || (go1 && (slot1.pipe == PIPE_EVEN));
    issue_ep_sel = go1 && (slot1.pipe == PIPE_EVEN);
    issue_op     = (go0 && (slot0.pipe == PIPE_ODD)) || (go1 && (slot1.pipe == PIPE_ODD));
    issue_op_sel = go1 && (slot1.pipe == PIPE_ODD);
    set_en[0]    = go0 && slot0.rt_wr;
    set_en[1]    = go1 && slot1.rt_wr;
    set_addr[0]  = slot0.rt;
    set_addr[1]  = slot1.rt;
    set_val[0]   = LAT_W'(slot0.lat) - LAT_W'(1);
    set_val[1]   = LAT_W'(slot1.lat) - LAT_W'(1);
  end

  // FSM state and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IS_PAIR;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  // Latencies below the forwarding minimum would let a consumer read too early.
  a_lat0: assert property (@(posedge clk) disable iff (rst)
    go0 |-> (slot0.lat >= SLOT_LAT_W'(MIN_LAT)));
  a_lat1: assert property (@(posedge clk) disable iff (rst)
    go1 |-> (slot1.lat >= SLOT_LAT_W'(MIN_LAT)));

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Scoreboard bench for spu_issue_ctrl: the driver queues the expected
// per-cycle outputs, the monitor pops and compares on the falling edge.
module tb_spu_issue_ctrl;
  import spu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pair_valid;
  issue_slot_t slot0;
  issue_slot_t slot1;
  logic        flush;
  logic        pair_ready;
  logic        issue_ep;
  logic        issue_ep_sel;
  logic        issue_op;
  logic        issue_op_sel;
  logic [15:0] stall_cnt;

  spu_issue_ctrl #(
    .NUM_REGS (128),
    .LAT_W    (3),
    .STALL_W  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pair_valid   (pair_valid),
    .slot0        (slot0),
    .slot1        (slot1),
    .flush        (flush),
    .pair_ready   (pair_ready),
    .issue_ep     (issue_ep),
    .issue_ep_sel (issue_ep_sel),
    .issue_op     (issue_op),
    .issue_op_sel (issue_op_sel),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  flags;   // {ep, ep_sel, op, op_sel, pair_ready}
    logic [15:0] stall;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   step_id = 0;

  function automatic issue_slot_t mk(input logic v, input pipe_e p, input int lat,
                                     input logic wr, input int rt, input logic [2:0] en,
                                     input int a, input int b, input int c);
    issue_slot_t s;
    s.valid  = v;
    s.pipe   = p;
    s.lat    = 3'(lat);
    s.rt_wr  = wr;
    s.rt     = 7'(rt);
    s.src_en = en;
    s.ra     = 7'(a);
    s.rb     = 7'(b);
    s.rc     = 7'(c);
    return s;
  endfunction

  // Queue the outputs required for the current cycle, then advance one cycle.
  task automatic step(input logic ep, input logic eps, input logic op, input logic ops,
                      input logic pr, input int st);
    exp_t e;
    e.flags = {ep, eps, op, ops, pr};
    e.stall = 16'(st);
    e.id    = step_id;
    step_id++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pair_valid = 1'b0;
    flush      = 1'b0;
    rst        = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Monitor: compare DUT outputs to the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({issue_ep, issue_ep_sel, issue_op, issue_op_sel, pair_ready} !== mon_e.flags) begin
        errors++;
        $display("FAIL step %0d issue{ep,ep_sel,op,op_sel,ready}: got %b expected %b",
                 mon_e.id, {issue_ep, issue_ep_sel, issue_op, issue_op_sel, pair_ready},
                 mon_e.flags);
      end
      checks++;
      if (stall_cnt !== mon_e.stall) begin
        errors++;
        $display("FAIL step %0d stall_cnt: got %0d expected %0d", mon_e.id, stall_cnt, mon_e.stall);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    pair_valid = 1'b0;
    flush      = 1'b0;
    slot0      = '0;
    slot1      = '0;
    @(posedge clk);
    #1;

    // Reset held with a ready pair presented: everything quiet.
    pair_valid = 1'b1;
    slot0 = mk(1, PIPE_EVEN, 2, 1, 3, 3'b001, 1, 0, 0);
    slot1 = mk(1, PIPE_ODD, 6, 1, 4, 3'b001, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Independent pair dual-issues in one cycle.
    step(1, 0, 1, 1, 1, 0);
    // Flush beats a ready pair; pair_valid=0 issues nothing.
    slot0 = mk(1, PIPE_EVEN, 2, 1, 12, 3'b000, 0, 0, 0);
    slot1 = '0;
    flush = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    flush      = 1'b0;
    pair_valid = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    pair_valid = 1'b1;
    step(1, 0, 0, 0, 1, 0);

    // Cross-pair RAW on r5 with lat=7: consumer issues at cycle 7.
    do_reset();
    pair_valid = 1'b1;
    slot0 = mk(1, PIPE_EVEN, 7, 1, 5, 3'b000, 0, 0, 0);
    slot1 = '0;
    step(1, 0, 0, 0, 1, 0);
    slot0 = mk(1, PIPE_EVEN, 2, 1, 6, 3'b001, 5, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, i);
    step(1, 0, 0, 0, 1, 6);
    pair_valid = 1'b0;
    step(0, 0, 0, 0, 0, 6);

    // Structural: both EVEN, then reset while in S1 returns to PAIR.
    do_reset();
    pair_valid = 1'b1;
    slot0 = mk(1, PIPE_EVEN, 2, 1, 10, 3'b000, 0, 0, 0);
    slot1 = mk(1, PIPE_EVEN, 3, 1, 11, 3'b000, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);

    // Intra-pair RAW: odd writes r9 lat=4, even slot1 reads r9.
    do_reset();
    pair_valid = 1'b1;
    slot0 = mk(1, PIPE_ODD, 4, 1, 9, 3'b000, 0, 0, 0);
    slot1 = mk(1, PIPE_EVEN, 2, 0, 0, 3'b010, 0, 9, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, i);
    step(1, 1, 0, 0, 1, 3);
    pair_valid = 1'b0;
    step(0, 0, 0, 0, 0, 3);

    // Flush in S1 while slot1 waits on r5; r5 keeps draining afterwards.
    do_reset();
    pair_valid = 1'b1;
    slot0 = mk(1, PIPE_ODD, 7, 1, 5, 3'b000, 0, 0, 0);
    slot1 = mk(1, PIPE_EVEN, 2, 0, 0, 3'b001, 5, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    flush = 1'b0;
    slot0 = mk(1, PIPE_EVEN, 2, 0, 0, 3'b001, 5, 0, 0);
    slot1 = '0;
    for (int i = 1; i < 5; i++) step(0, 0, 0, 0, 0, i);
    step(1, 0, 0, 0, 1, 5);

    // WAW on r20: second writer waits for the first writer's countdown.
    do_reset();
    pair_valid = 1'b1;
    slot0 = mk(1, PIPE_EVEN, 3, 1, 20, 3'b000, 0, 0, 0);
    slot1 = '0;
    step(1, 0, 0, 0, 1, 0);
    slot0 = mk(1, PIPE_ODD, 2, 1, 20, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 2);
    pair_valid = 1'b0;

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
